sv_bus_str2bus_demux: RTL

SV_BUS_STR2BUS_DEMUX -- requirements
Module: sv_bus_str2bus_demux

---
 rtl/sv_bus_str2bus_demux_pkg.sv | 18 +
 rtl/sv_bus_str2bus_demux_fifo.sv | 56 +++++
 rtl/sv_bus_str2bus_demux.sv | 86 ++++++++
 3 files changed

// File: rtl/sv_bus_str2bus_demux_pkg.sv
// Shared bus constants and types for the stream-to-bus demux.
// Provides default address/data widths and the beats-per-packet helper.
package package_bus;

    localparam int AW_DEF = 32;
    localparam int DW_DEF = 32;

    typedef struct packed {
        logic [AW_DEF-1:0] adr;
        logic [DW_DEF-1:0] dat;
    } t_bus;

    // Number of stream beats needed to fill one {adr,dat} packet.
    function automatic int beats(input int aw, input int dw, input int sw);
        return (aw + dw) / sw;
    endfunction

endpackage

// File: rtl/sv_bus_str2bus_demux_fifo.sv
// Packet FIFO (sv_bus_fifo) used as the output queue of sv_bus_str2bus_demux.
// Show-ahead read: rdat always presents the oldest entry.
module sv_bus_fifo
    import package_bus::*;
#(
    parameter int width = 64,
    parameter int depth = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [width-1:0]             wdat,
    output logic [width-1:0]             rdat,
    output logic [$clog2(depth+1)-1:0]   lvl
);

    localparam int PW = (depth > 1) ? $clog2(depth) : 1;
    localparam int LW = $clog2(depth + 1);

    logic [width-1:0] mem [depth];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(depth - 1)) ? '0 : p + PW'(1);
    endfunction

    assign do_pop  = pop & (lvl != '0);
    assign do_push = push & ((lvl != LW'(depth)) | do_pop);
    assign rdat    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            lvl    <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   lvl <= lvl + LW'(1);
                2'b01:   lvl <= lvl - LW'(1);
                default: lvl <= lvl;
            endcase
        end
    end

    // NOTE: storage is not reset; validity is tracked by lvl and the pointers only.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdat;
    end

endmodule

// File: rtl/sv_bus_str2bus_demux.sv
// Assembles SW-bit stream beats into {adr,dat} packets and queues them for the bus.
// Optional framing check on str_lst is compiled in with SV_BUS_STR2BUS_FRAME_EN.
module sv_bus_str2bus_demux
    import package_bus::*;
#(
    parameter int SW = 8,
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF,
    parameter int FD = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      str_vld,
    input  logic [SW-1:0]             str_bus,
    input  logic                      str_lst,
    output logic                      str_rdy,
    output logic                      bus_vld,
    output logic [AW-1:0]             bus_adr,
    output logic [DW-1:0]             bus_dat,
    input  logic                      bus_rdy,
    output logic [$clog2(FD+1)-1:0]   bus_lvl,
    output logic                      err
);

    localparam int N  = beats(AW, DW, SW);
    localparam int PW = AW + DW;
    localparam int CW = $clog2(N);
    localparam int LW = $clog2(FD + 1);

    logic [CW-1:0] cnt;
    logic [PW-1:0] pkt;
    logic [PW-1:0] head;
    logic          push_q;
    logic          last_beat;
    logic          str_trn;
    logic          bus_trn;
    logic          frame_bad;

    assign last_beat = (cnt == CW'(N - 1));
    assign bus_vld   = (bus_lvl != '0);
    assign bus_trn   = bus_vld & bus_rdy;
    // The last beat may only enter when its packet is guaranteed a FIFO slot.
    assign str_rdy   = ~last_beat | (bus_lvl < LW'(FD)) | bus_trn;
    assign str_trn   = str_vld & str_rdy;

`ifdef SV_BUS_STR2BUS_FRAME_EN
    assign frame_bad = str_trn & (str_lst != last_beat);
`else
    logic unused_lst;
    assign unused_lst = str_lst;
    assign frame_bad  = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            push_q <= 1'b0;
            err    <= 1'b0;
        end else begin
            push_q <= str_trn & last_beat & ~frame_bad;
            err    <= frame_bad;
            if (str_trn) cnt <= (last_beat | frame_bad) ? '0 : cnt + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (str_trn) pkt[cnt*SW +: SW] <= str_bus;
    end

    sv_bus_fifo #(
        .width (PW),
        .depth (FD)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (push_q),
        .pop  (bus_trn),
        .wdat (pkt),
        .rdat (head),
        .lvl  (bus_lvl)
    );

    assign {bus_adr, bus_dat} = head;

endmodule
